// File: rtl/acc_diff.sv
// Recovers increments x[n] = q[n] - q[n-1] from a running-sum stream; 1-cycle latency, full rate.
// Single output register: input stalls only while a held result is not taken downstream.
module acc_diff #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_x;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;

  logic             w_acc_in;
  logic             w_acc_out;
  logic [WIDTH-1:0] w_base;
  logic [CNT_W-1:0] w_cnt_base;

  // Ready depends only on the output register, never on in_valid.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_acc_in   = in_valid && in_ready;
  assign w_acc_out  = r_out_valid && out_ready;
  assign w_base     = clr ? '0 : r_prev;
  assign w_cnt_base = clr ? '0 : r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= '0;
      r_x         <= '0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else if (w_acc_in) begin
      r_x         <= q - w_base;
      r_prev      <= q;
      r_out_valid <= 1'b1;
      r_cnt       <= w_cnt_base + CNT_W'(1);
    end else begin
      // clr restarts the difference chain but never drops a pending result.
      if (clr) begin
        r_prev <= '0;
        r_cnt  <= '0;
      end
      if (w_acc_out) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign x         = r_x;
  assign cnt       = r_cnt;

endmodule

// File: tb/tb_acc_diff.sv
// Directed and randomized checks of acc_diff against an increment-queue reference model.
module tb_acc_diff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] q = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] x;
  logic [31:0] cnt;

  int errors = 0;
  int checks = 0;

  // Handshake snapshot taken at the negedge before each posedge
  logic        h_in;
  logic        h_out;
  logic        h_rdy;
  logic [31:0] h_x;

  acc_diff #(.WIDTH(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .q(q),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic iv, input logic [31:0] qv, input logic ordy, input logic c);
    in_valid  = iv;
    q         = qv;
    out_ready = ordy;
    clr       = c;
    @(negedge clk);
    h_in  = in_valid && in_ready;
    h_out = out_valid && out_ready;
    h_rdy = in_ready;
    h_x   = x;
    @(posedge clk);
    #1;
  endtask

  int unsigned tri_q[6] = '{0, 1, 3, 6, 10, 15};
  int unsigned expq[$];
  int unsigned next_inc;
  int unsigned sum;
  int unsigned emitted;
  int unsigned exp_x;

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x", x, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_in_ready", in_ready, 1);

    // Basic stream
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, tri_q[i], 1'b1, 1'b0);
      chk("basic_vld", out_valid, 1);
      chk("basic_x", x, i);
      chk("basic_cnt", cnt, i + 1);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("basic_drain_vld", out_valid, 0);
    chk("basic_final_cnt", cnt, 6);

    // Backpressure (clr restarts the chain so the first x is 5)
    cyc(1'b1, 32'd5, 1'b0, 1'b1);
    chk("bp_first_x", x, 5);
    chk("bp_first_cnt", cnt, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'd12, 1'b0, 1'b0);
      chk("bp_no_accept", h_in, 0);
      chk("bp_hold_x", x, 5);
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_cnt", cnt, 1);
    end
    cyc(1'b1, 32'd12, 1'b1, 1'b0);
    chk("bp_emit1_hs", h_out, 1);
    chk("bp_emit1_x", h_x, 5);
    chk("bp_second_x", x, 7);
    chk("bp_second_cnt", cnt, 2);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("bp_emit2_x", h_x, 7);
    chk("bp_drain_vld", out_valid, 0);

    // Wrap-around
    cyc(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    chk("wrap_first_x", x, 32'hFFFF_FFFE);
    cyc(1'b1, 32'h0000_0003, 1'b1, 1'b0);
    chk("wrap_second_x", x, 32'h0000_0005);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Clear concurrent with accept
    cyc(1'b1, 32'd100, 1'b1, 1'b0);
    chk("clr_pre_x", x, 97);
    cyc(1'b1, 32'd40, 1'b1, 1'b1);
    chk("clr_acc_x", x, 40);
    chk("clr_acc_cnt", cnt, 1);
    cyc(1'b1, 32'd50, 1'b1, 1'b0);
    chk("clr_next_x", x, 10);
    chk("clr_next_cnt", cnt, 2);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Clear without accept keeps the pending output
    cyc(1'b1, 32'd20, 1'b0, 1'b0);
    chk("clr_hold_neg_x", x, 32'hFFFF_FFE2);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("clr_hold_vld", out_valid, 1);
    chk("clr_hold_x", x, 32'hFFFF_FFE2);
    chk("clr_hold_cnt", cnt, 0);
    cyc(1'b1, 32'd8, 1'b1, 1'b0);
    chk("clr_hold_emit", h_x, 32'hFFFF_FFE2);
    chk("clr_hold_after_x", x, 8);
    chk("clr_hold_after_cnt", cnt, 1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Reset mid-operation
    cyc(1'b1, 32'd7, 1'b0, 1'b1);
    chk("midrst_pending_x", x, 7);
    rst = 1'b1;
    cyc(1'b1, 32'd3, 1'b1, 1'b1);
    rst = 1'b0;
    chk("midrst_vld", out_valid, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_x", x, 0);
    cyc(1'b1, 32'd9, 1'b1, 1'b0);
    chk("midrst_first_x", x, 9);
    chk("midrst_first_cnt", cnt, 1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Long randomized run from an accumulator of increments 0..1337
    cyc(1'b0, 32'd0, 1'b1, 1'b1);
    next_inc = 0;
    sum      = 0;
    emitted  = 0;
    for (int c = 0; c < 20000 && !(next_inc > 1337 && expq.size() == 0); c++) begin
      logic iv;
      logic ordy;
      int unsigned expq_before;
      iv   = (next_inc <= 1337) && ($urandom_range(3) != 0);
      ordy = ($urandom_range(2) != 0);
      expq_before = expq.size();
      cyc(iv, sum + next_inc, ordy, 1'b0);
      chk("run_in_ready", h_rdy, (expq_before == 0) || ordy);
      if (h_out) begin
        if (expq.size() == 0) begin
          chk("run_spurious_emit", 1, 0);
        end else begin
          exp_x = expq.pop_front();
          chk("run_x", h_x, exp_x);
          emitted++;
        end
      end
      if (h_in) begin
        expq.push_back(next_inc);
        sum = sum + next_inc;
        next_inc++;
      end
    end
    chk("run_all_sent", next_inc, 1338);
    chk("run_all_emitted", emitted, 1338);
    chk("run_final_cnt", cnt, 1338);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_diff.md
Name: acc_diff

Overview:
- Inverse of the running-sum accumulator. Consumes a stream of accumulated sums `q` and recovers the original increments `x[n] = q[n] - q[n-1]`.
- Sits at the output of an accumulator datapath (decoder side) or in a bench as a checker.
- Streaming valid/ready on both sides; 1-cycle latency; full throughput.

Parameters:
- WIDTH, 32, data width of `q` and `x`; all arithmetic is modulo 2^WIDTH.
- CNT_W, 32, width of the emitted-sample counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- clr  input  1  synchronous restart: previous sum treated as 0 and counter zeroed.
- in_valid  input  1  `q` is valid this cycle.
- in_ready  output  1  block accepts `q` this cycle.
- q  input  WIDTH  accumulated sum sample.
- out_valid  output  1  `x` holds a valid difference.
- out_ready  input  1  downstream accepts `x` this cycle.
- x  output  WIDTH  recovered increment.
- cnt  output  CNT_W  number of samples accepted since reset/clr.

Behaviour:
- State: `prev` (WIDTH), output register `x`/`out_valid`, counter `cnt`.
- Reset (`rst=1` at posedge):
  - `prev=0`, `x=0`, `out_valid=0`, `cnt=0`.
  - `rst` overrides `clr` and any handshake in the same cycle.
- Ready rule: `in_ready = !out_valid || out_ready`. This is combinational from `out_valid` and `out_ready` only, with no dependence on `in_valid`.
- Accept: `acc_in = in_valid && in_ready`.
- Emit: `acc_out = out_valid && out_ready`.
- On `acc_in` at a posedge:
  - `x <= q - p` (mod 2^WIDTH), where `p = clr ? 0 : prev`.
  - `prev <= q`.
  - `out_valid <= 1`.
  - `cnt <= (clr ? 0 : cnt) + 1`, wrapping mod 2^CNT_W.
- On `acc_out` without `acc_in`: `out_valid <= 0`; `x` holds its last value.
- Simultaneous `acc_out` and `acc_in`: the old `x` is consumed and the new `x` is loaded. `out_valid` stays 1, so there is no bubble.
- Output stable under backpressure: while `out_valid=1` and `out_ready=0`:
  - `x` does not change;
  - `in_ready=0`;
  - `q` is ignored.
- `clr` without `acc_in`: `prev <= 0`, `cnt <= 0`. A pending `out_valid`/`x` is NOT flushed and is still delivered.
- First sample after reset or `clr`: `x = q`. This matches an accumulator starting from 0.
- Latency: a `q` accepted at edge n appears on `x` with `out_valid=1` after edge n. Sustained rate is 1 sample/cycle when `out_ready=1`.
- Wrap-around: the subtraction is a plain WIDTH-bit difference. A sum that wrapped past 2^WIDTH still yields the correct increment. No overflow flag.
- `in_valid` low: no state change except draining via `acc_out` and the `clr` effects above.
- Reset mid-stream: the pending output is discarded (`out_valid=0`). The next accepted `q` is treated as the first sample.

Test Plan:
- Basic stream: `out_ready=1`, feed `q = 0,1,3,6,10,15` on consecutive cycles → `x = 0,1,2,3,4,5`, one per cycle, 1-cycle latency, `cnt` ends at 6.
- Backpressure: feed `q = 5,12`, hold `out_ready=0` for 3 cycles after the first accept → `x=5` held stable, `in_ready=0` for those cycles. Release → `x=5` then `x=7`, no sample lost or duplicated.
- Wrap: WIDTH=32, `q = 0xFFFFFFFE` then `0x00000003` → second `x = 0x00000005`.
- Clear with concurrent accept: after `q=100`, assert `clr` in the same cycle as `q=40` → `x=40`, `cnt=1`. Next `q=50` → `x=10`.
- Reset mid-operation: `out_valid=1`, `x=7` pending with `out_ready=0`, pulse `rst` → next cycle `out_valid=0`, `cnt=0`. Then `q=9` → `x=9`.
- Long run: drive from an accumulator with increments `i = 0..1337` under random `out_ready` → every `x` equals `i` in order, final `cnt = 1338`.
